// File: rtl/fetch_queue_if.sv
// Bundle between the fetch queue, instruction memory, the ALU redirect path and decode.
// The queue side uses modport master; the environment (imem, ALU, decode) uses slave.
interface fetch_queue_if #(
    parameter int AW = 3
);
    logic [31:0] imem_addr;
    logic [31:0] imem_d0;
    logic [31:0] imem_d1;
    logic        jmp_en;
    logic [31:0] jmp_addr;
    logic [1:0]  take;
    logic [31:0] ins0;
    logic [31:0] ins1;
    logic [31:0] pc0;
    logic [31:0] pc1;
    logic        v0;
    logic        v1;
    logic [AW:0] count;
    logic        full;

    modport master (
        output imem_addr,
        input  imem_d0,
        input  imem_d1,
        input  jmp_en,
        input  jmp_addr,
        input  take,
        output ins0,
        output ins1,
        output pc0,
        output pc1,
        output v0,
        output v1,
        output count,
        output full
    );

    modport slave (
        input  imem_addr,
        output imem_d0,
        output imem_d1,
        output jmp_en,
        output jmp_addr,
        output take,
        input  ins0,
        input  ins1,
        input  pc0,
        input  pc1,
        input  v0,
        input  v1,
        input  count,
        input  full
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: fetches aligned pc/pc+1 pairs into a circular buffer
// and presents the two oldest entries to decode; an ALU redirect flushes and reloads pc.
module fetch_queue #(
    parameter int          DEPTH    = 8,
    parameter int          AW       = 3,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input logic          clk,
    input logic          rst,
    fetch_queue_if.master bus
);

    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    // Decode handshake: v0/v1 say how many head entries are valid; decode answers
    // the same cycle with take (0..2, 3 means 2) and entries leave at the next edge.
    // Taking more than is valid is clamped, so decode can never underflow the queue.

    logic [31:0]   pc;
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [AW:0]   cnt;

    logic [31:0] instr [DEPTH];
    logic [31:0] tag   [DEPTH];

    logic [1:0]    take_c;
    logic [AW:0]   take_w;
    logic [AW:0]   pop;
    logic [AW:0]   after_pop;
    logic [AW+1:0] room_need;
    logic          push;
    logic [AW:0]   cnt_next;
    logic [AW-1:0] tail_p1;
    logic [AW-1:0] head_p1;

    always_comb begin
        take_c    = (bus.take == 2'd3) ? 2'd2 : bus.take;
        take_w    = (AW + 1)'(take_c);
        pop       = (take_w > cnt) ? cnt : take_w;
        after_pop = cnt - pop;
        room_need = {1'b0, after_pop} + (AW + 2)'(2);
        // Pairs go in whole: a single free slot stalls fetch rather than splitting.
        push      = !bus.jmp_en && (room_need <= {1'b0, DEPTH_C});
        cnt_next  = after_pop + (push ? (AW + 1)'(2) : '0);
        tail_p1   = tail + 1'b1;
        head_p1   = head + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc   <= RESET_PC;
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else if (bus.jmp_en) begin
            pc   <= bus.jmp_addr;
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            head <= head + pop[AW-1:0];
            cnt  <= cnt_next;
            if (push) begin
                tail <= tail + AW'(2);
                pc   <= pc + 32'd2;
            end
        end
    end

    // Storage carries no reset; slots are only observable through the valid flags.
    always_ff @(posedge clk) begin
        if (rst && push) begin
            instr[tail]    <= bus.imem_d0;
            tag[tail]      <= pc;
            instr[tail_p1] <= bus.imem_d1;
            tag[tail_p1]   <= pc + 32'd1;
        end
    end

    always_comb begin
        bus.imem_addr = pc;
        bus.v0        = (cnt != '0);
        bus.v1        = (cnt >= (AW + 1)'(2));
        bus.ins0      = bus.v0 ? instr[head]    : 32'h0;
        bus.pc0       = bus.v0 ? tag[head]      : 32'h0;
        bus.ins1      = bus.v1 ? instr[head_p1] : 32'h0;
        bus.pc1       = bus.v1 ? tag[head_p1]   : 32'h0;
        bus.count     = cnt;
        bus.full      = (cnt == DEPTH_C);
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: imem returns address*16, a negedge monitor checks
// every consumed entry against an expected queue, and the driver checks occupancy/pc.
module tb_fetch_queue;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  logic [63:0] exp_q[$];

  fetch_queue_if #(.AW(3)) bus ();

  fetch_queue #(.DEPTH(8), .AW(3), .RESET_PC(32'h0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Instruction memory model: word at address a is a*16.
  assign bus.imem_d0 = bus.imem_addr << 4;
  assign bus.imem_d1 = (bus.imem_addr + 32'd1) << 4;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic exp_push(input logic [31:0] p);
    logic [31:0] p1;
    p1 = p + 32'd1;
    exp_q.push_back({p, p << 4});
    exp_q.push_back({p1, p1 << 4});
  endtask

  task automatic tick(input logic [1:0] t, input logic j, input logic [31:0] ja,
                      input logic r);
    bus.take     = t;
    bus.jmp_en   = j;
    bus.jmp_addr = ja;
    rst          = r;
    @(posedge clk);
    #1;
    if (j || !r) exp_q.delete();
  endtask

  // scoreboard monitor: compares each entry decode consumes this cycle
  always @(negedge clk) begin
    int n;
    int avail;
    logic [63:0] e;
    logic [63:0] act;
    if (rst && !bus.jmp_en) begin
      n     = (bus.take == 2'd3) ? 2 : int'(bus.take);
      avail = int'(bus.v0) + int'(bus.v1);
      if (n > avail) n = avail;
      for (int i = 0; i < n; i++) begin
        act = (i == 0) ? {bus.pc0, bus.ins0} : {bus.pc1, bus.ins1};
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL pop_underrun: got pc=%h ins=%h expected no entry", act[63:32], act[31:0]);
        end else begin
          e = exp_q.pop_front();
          if (act !== e) begin
            failures++;
            $display("FAIL pop_entry: got pc=%h ins=%h expected pc=%h ins=%h",
                     act[63:32], act[31:0], e[63:32], e[31:0]);
          end
        end
      end
    end
  end

  initial begin
    checks       = 0;
    failures     = 0;
    rst          = 1'b0;
    bus.take     = 2'd0;
    bus.jmp_en   = 1'b0;
    bus.jmp_addr = 32'h0;

    // reset
    tick(2'd0, 1'b0, 32'h0, 1'b0);
    tick(2'd0, 1'b0, 32'h0, 1'b0);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_imem_addr", bus.imem_addr, 32'h0);
    chk("rst_v0", 32'(bus.v0), 32'd0);
    chk("rst_v1", 32'(bus.v1), 32'd0);
    chk("rst_ins0", bus.ins0, 32'h0);
    chk("rst_pc1", bus.pc1, 32'h0);
    chk("rst_full", 32'(bus.full), 32'd0);

    // fill with take=0
    for (int k = 1; k <= 4; k++) begin
      chk("fill_imem_addr_pre", bus.imem_addr, 32'(2 * (k - 1)));
      exp_push(32'(2 * (k - 1)));
      tick(2'd0, 1'b0, 32'h0, 1'b1);
      chk("fill_count", 32'(bus.count), 32'(2 * k));
    end
    chk("fill_full", 32'(bus.full), 32'd1);
    tick(2'd0, 1'b0, 32'h0, 1'b1);
    chk("fill_hold_count", 32'(bus.count), 32'd8);
    chk("fill_hold_addr", bus.imem_addr, 32'h8);
    chk("fill_ins0", bus.ins0, 32'h00);
    chk("fill_pc0", bus.pc0, 32'h0);
    chk("fill_ins1", bus.ins1, 32'h10);
    chk("fill_pc1", bus.pc1, 32'h1);

    // steady drain across several pointer wraps
    for (int i = 0; i < 10; i++) begin
      exp_push(32'(8 + 2 * i));
      tick(2'd2, 1'b0, 32'h0, 1'b1);
      chk("drain_count", 32'(bus.count), 32'd8);
      chk("drain_pc0", bus.pc0, 32'(2 * (i + 1)));
      chk("drain_addr", bus.imem_addr, 32'(10 + 2 * i));
    end

    // single-take stall at one free slot
    tick(2'd1, 1'b0, 32'h0, 1'b1);
    chk("stall_count_a", 32'(bus.count), 32'd7);
    chk("stall_addr_a", bus.imem_addr, 32'd28);
    tick(2'd0, 1'b0, 32'h0, 1'b1);
    chk("stall_count_b", 32'(bus.count), 32'd7);
    chk("stall_addr_b", bus.imem_addr, 32'd28);
    chk("stall_full_b", 32'(bus.full), 32'd0);
    exp_push(32'd28);
    tick(2'd1, 1'b0, 32'h0, 1'b1);
    chk("stall_count_c", 32'(bus.count), 32'd8);
    chk("stall_addr_c", bus.imem_addr, 32'd30);
    chk("stall_pc0_c", bus.pc0, 32'd22);

    // redirect, refill to six, redirect with take=2
    tick(2'd2, 1'b1, 32'h80, 1'b1);
    chk("jmp1_count", 32'(bus.count), 32'd0);
    chk("jmp1_addr", bus.imem_addr, 32'h80);
    for (int k = 0; k < 3; k++) begin
      exp_push(32'h80 + 32'(2 * k));
      tick(2'd0, 1'b0, 32'h0, 1'b1);
    end
    chk("refill_count", 32'(bus.count), 32'd6);
    chk("refill_addr", bus.imem_addr, 32'h86);
    tick(2'd2, 1'b1, 32'h40, 1'b1);
    chk("jmp2_count", 32'(bus.count), 32'd0);
    chk("jmp2_v0", 32'(bus.v0), 32'd0);
    chk("jmp2_v1", 32'(bus.v1), 32'd0);
    chk("jmp2_ins0", bus.ins0, 32'h0);
    chk("jmp2_addr", bus.imem_addr, 32'h40);
    exp_push(32'h40);
    tick(2'd0, 1'b0, 32'h0, 1'b1);
    chk("jmp2_ins0_next", bus.ins0, 32'h400);
    chk("jmp2_pc0_next", bus.pc0, 32'h40);
    chk("jmp2_ins1_next", bus.ins1, 32'h410);
    chk("jmp2_pc1_next", bus.pc1, 32'h41);

    // over-take (take=3) at count 2, 0 and 3
    exp_push(32'h42);
    tick(2'd3, 1'b0, 32'h0, 1'b1);
    chk("over2_count", 32'(bus.count), 32'd2);
    chk("over2_pc0", bus.pc0, 32'h42);
    chk("over2_ins0", bus.ins0, 32'h420);
    chk("over2_addr", bus.imem_addr, 32'h44);
    tick(2'd3, 1'b1, 32'h10, 1'b1);
    chk("over0_pre_count", 32'(bus.count), 32'd0);
    exp_push(32'h10);
    tick(2'd3, 1'b0, 32'h0, 1'b1);
    chk("over0_count", 32'(bus.count), 32'd2);
    chk("over0_pc0", bus.pc0, 32'h10);
    exp_push(32'h12);
    tick(2'd1, 1'b0, 32'h0, 1'b1);
    chk("take1_count", 32'(bus.count), 32'd3);
    chk("take1_pc0", bus.pc0, 32'h11);
    exp_push(32'h14);
    tick(2'd3, 1'b0, 32'h0, 1'b1);
    chk("over3_count", 32'(bus.count), 32'd3);
    chk("over3_pc0", bus.pc0, 32'h13);
    chk("over3_pc1", bus.pc1, 32'h14);
    chk("over3_addr", bus.imem_addr, 32'h16);

    // 32-bit pc wrap inside a pair
    tick(2'd0, 1'b1, 32'hFFFF_FFFF, 1'b1);
    chk("wrap_addr_pre", bus.imem_addr, 32'hFFFF_FFFF);
    exp_push(32'hFFFF_FFFF);
    tick(2'd0, 1'b0, 32'h0, 1'b1);
    chk("wrap_pc0", bus.pc0, 32'hFFFF_FFFF);
    chk("wrap_ins0", bus.ins0, 32'hFFFF_FFF0);
    chk("wrap_pc1", bus.pc1, 32'h0);
    chk("wrap_v1", 32'(bus.v1), 32'd1);
    chk("wrap_addr", bus.imem_addr, 32'h1);

    // reset beats redirect mid-operation
    exp_push(32'h1);
    tick(2'd0, 1'b0, 32'h0, 1'b1);
    chk("pre_rst_count4", 32'(bus.count), 32'd4);
    exp_push(32'h3);
    tick(2'd1, 1'b0, 32'h0, 1'b1);
    chk("pre_rst_count5", 32'(bus.count), 32'd5);
    chk("pre_rst_pc0", bus.pc0, 32'h0);
    tick(2'd2, 1'b1, 32'h40, 1'b0);
    chk("mid_rst_count", 32'(bus.count), 32'd0);
    chk("mid_rst_addr", bus.imem_addr, 32'h0);
    chk("mid_rst_v0", 32'(bus.v0), 32'd0);
    chk("mid_rst_ins0", bus.ins0, 32'h0);
    chk("mid_rst_ins1", bus.ins1, 32'h0);
    chk("mid_rst_pc0", bus.pc0, 32'h0);
    chk("mid_rst_pc1", bus.pc1, 32'h0);
    exp_push(32'h0);
    tick(2'd0, 1'b0, 32'h0, 1'b1);
    chk("post_rst_ins1", bus.ins1, 32'h10);
    chk("post_rst_pc1", bus.pc1, 32'h1);
    chk("post_rst_addr", bus.imem_addr, 32'h2);
    exp_push(32'h2);
    tick(2'd2, 1'b0, 32'h0, 1'b1);
    chk("post_rst_count", 32'(bus.count), 32'd2);
    chk("post_rst_pc0", bus.pc0, 32'h2);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction-fetch front end of the dual-issue core; it is the writer side of the instruction buffer that decode drains.
- Each cycle it can fetch an aligned-pair window (word addresses pc and pc+1) from instruction memory and push both words, tagged with their PCs, into a circular FIFO.
- It presents the two oldest entries to decode. Decode reports how many it consumed (0, 1 or 2).
- An ALU jump/branch redirect flushes the FIFO and reloads the PC.

Parameters:
- DEPTH, 8, FIFO entries. Power of two, at least 4.
- AW, 3, pointer width, equal to log2(DEPTH).
- RESET_PC, 32'h0, fetch address loaded at reset.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-low reset (rst==0 resets on posedge clk)
- imem_addr  out  32  word address of fetch window; equals pc register (combinational from register)
- imem_d0  in  32  instruction at imem_addr, valid same cycle
- imem_d1  in  32  instruction at imem_addr+1, valid same cycle
- jmp_en  in  1  redirect request from ALU
- jmp_addr  in  32  redirect target (word address)
- take  in  2  entries consumed by decode this cycle (0/1/2; 3 treated as 2)
- ins0  out  32  head instruction, 0 when invalid
- ins1  out  32  head+1 instruction, 0 when invalid
- pc0  out  32  PC of ins0, 0 when invalid
- pc1  out  32  PC of ins1, 0 when invalid
- v0  out  1  ins0 valid (count>=1)
- v1  out  1  ins1 valid (count>=2)
- count  out  AW+1  current occupancy, 0..DEPTH
- full  out  1  count==DEPTH

Behaviour:
- State: pc[31:0], head[AW-1:0], tail[AW-1:0], cnt[AW:0], plus the mem arrays instr[DEPTH] and tag[DEPTH].
- Reset (rst==0 at posedge): pc=RESET_PC, head=tail=cnt=0.
  - All outputs 0 except imem_addr, which is RESET_PC.
  - Array contents are don't-care.
- Outputs ins*/pc*/v*/count/full are combinational from registered state. Zero latency from push to visibility is not required: data is visible the cycle after the push edge.
- Effective pop: pop = min(take_clamped, cnt), where take_clamped = (take==3) ? 2 : take. Over-take never underflows.
- Push condition: push = !jmp_en && (cnt - pop + 2 <= DEPTH), evaluated from pre-edge cnt.
  - When push is true, write instr[tail]=imem_d0, tag[tail]=pc, instr[tail+1]=imem_d1, tag[tail+1]=pc+1.
  - Then tail += 2 (mod DEPTH) and pc += 2.
- Pairs are always pushed whole. No single-word push, so a slot of 1 free entry stalls fetch.
- Occupancy update: cnt_next = cnt - pop + (push ? 2 : 0); head += pop (mod DEPTH).
- Redirect (jmp_en==1, not in reset) has priority over pop and push:
  - head=tail=cnt=0, pc=jmp_addr, no push.
  - take is ignored that cycle.
  - The next cycle fetches from jmp_addr.
- Reset has priority over redirect.
- Simultaneous pop and push when full: allowed if pop frees enough entries (e.g. cnt=DEPTH, take=2 -> push occurs, cnt stays DEPTH).
- Pointer wrap-around: head/tail wrap modulo DEPTH. A pair may straddle the wrap (tail=DEPTH-1 writes entries DEPTH-1 and 0).
- PC arithmetic is 32-bit modular; pc=32'hFFFFFFFF with push gives tags FFFFFFFF and 0, then pc=1.
- Invalid output slots drive 0, which decode treats as NOP.
- No imem request/ack: imem_addr is read combinationally, and imem_d0/d1 are sampled at the push edge.
- Reset mid-operation discards all buffered entries. Outputs are 0 in the cycle after the reset edge.

Test Plan:
- Reset, then fill: rst=0 for 2 cycles, then rst=1, imem returns word = address*16, take=0.
  - Cycle-by-cycle count reads 2, 4, 6, 8; full=1 after the 4th push.
  - imem_addr reads 0, 2, 4, 6, then holds 8.
  - ins0=0x00 pc0=0; ins1=0x10 pc1=1.
- Steady drain: FIFO full (DEPTH=8), take=2 every cycle.
  - count stays 8; pc0 advances 0, 2, 4...
  - No entry is lost or duplicated across head/tail wrap; compare against a reference queue.
- Single-take stall: cnt=7, take=0.
  - No push; count=7, imem_addr unchanged.
  - Next cycle take=1: push happens, count=8.
- Redirect with simultaneous take: cnt=6, take=2, jmp_en=1, jmp_addr=0x40.
  - Next cycle count=0, v0=v1=0, ins0=0, imem_addr=0x40.
  - Following cycle ins0=mem[0x40], pc0=0x40, ins1 pc1=0x41.
- Over-take: cnt=1, take=3.
  - pop=1, push 2 -> count=2; no underflow.
  - head points to the pushed pair.
- Reset mid-operation: cnt=5, jmp_en=1, rst=0 in the same cycle.
  - Reset wins: pc=RESET_PC (0), count=0, all data outputs 0.
